// File: rtl/i2c_master_16b.sv
// i2c_master_16b
//   I2C master for slaves with a 16-bit register address and 8-bit data.
//   Write frame: S, {SLAVE_ADDR,W}, addr[15:8], addr[7:0], data, P.
//   Read frame:  S, {SLAVE_ADDR,W}, addr[15:8], addr[7:0], Sr, {SLAVE_ADDR,R}, data, NACK, P.
//   A NACK in any ACK slot ends the frame with a STOP and sets i2c_ack.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   i2c_exec    1-cycle start pulse (only honoured in IDLE)
//   i2c_rh_wl   1 = read, 0 = write
//   i2c_data    [23:8] register address, [7:0] write data
//   i2c_data_r  byte returned by the last successful read
//   i2c_done    1-cycle pulse at the end of each transaction
//   i2c_ack     1 when the slave NACKed during the last transaction
//   scl         I2C clock (push-pull)
//   sda         I2C data, open-drain (drives 0 or releases)
module i2c_master_16b #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h59,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned I2C_FREQ   = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic        i2c_rh_wl,
  input  logic [23:0] i2c_data,
  output logic [7:0]  i2c_data_r,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        scl,
  inout  wire         sda
);

  localparam int unsigned QDIV  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned DIV_W = $clog2(QDIV);

  typedef enum logic [3:0] {
    IDLE, START, DEV_W, ADDR_H, ADDR_L, WR_DATA,
    RESTART, DEV_R, RD_DATA, MNACK, STOP, DONE
  } state_t;

  state_t             state_q;
  state_t             nxt_state;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick;
  logic [3:0]         bit_q;
  logic [1:0]         qtr_q;
  logic [5:0]         step;
  logic [23:0]        dat_q;
  logic               rw_q;
  logic [7:0]         tx_q;
  logic [7:0]         nxt_byte;
  logic [7:0]         rx_q;
  logic               smp_q;
  logic               scl_q;
  logic               sda_oe_q;
  logic               done_q;
  logic               ack_q;
  logic [7:0]         data_r_q;

  // Quarter-bit tick generator; held at zero while idle so every frame
  // starts with a full quarter period.
  assign tick = (state_q != IDLE) && (div_q == DIV_W'(QDIV - 1));

  always_comb begin
    if (state_q == IDLE || tick) div_d = '0;
    else                         div_d = div_q + DIV_W'(1);
  end

  // {bit_q, qtr_q} doubles as a plain tick index (bit*4 + quarter) for the
  // START, RESTART and STOP sequences.
  assign step = {bit_q, qtr_q};

  // Successor of each byte state once its ACK slot was answered with ACK.
  always_comb begin
    nxt_state = STOP;
    nxt_byte  = '0;
    case (state_q)
      DEV_W:   begin nxt_state = ADDR_H; nxt_byte = dat_q[23:16]; end
      ADDR_H:  begin nxt_state = ADDR_L; nxt_byte = dat_q[15:8];  end
      ADDR_L:  begin nxt_state = rw_q ? RESTART : WR_DATA; nxt_byte = dat_q[7:0]; end
      DEV_R:   nxt_state = RD_DATA;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      qtr_q    <= '0;
      dat_q    <= '0;
      rw_q     <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      smp_q    <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      data_r_q <= '0;
    end else begin
      div_q  <= div_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i2c_exec) begin
            dat_q   <= i2c_data;
            rw_q    <= i2c_rh_wl;
            ack_q   <= 1'b0;
            tx_q    <= {SLAVE_ADDR, 1'b0};
            bit_q   <= '0;
            qtr_q   <= '0;
            state_q <= START;
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          if (tick) begin
            {bit_q, qtr_q} <= step + 6'd1;
            case (state_q)
              // SDA falls at tick 3 with SCL high, SCL falls at tick 6.
              START: begin
                case (step)
                  6'd3: sda_oe_q <= 1'b1;
                  6'd6: scl_q    <= 1'b0;
                  6'd8: begin
                    {bit_q, qtr_q} <= '0;
                    state_q        <= DEV_W;
                  end
                  default: ;
                endcase
              end

              DEV_W, ADDR_H, ADDR_L, WR_DATA, DEV_R: begin
                case (qtr_q)
                  2'd0: begin
                    scl_q    <= 1'b0;
                    // bit 8 is the slave's ACK slot: release the line
                    sda_oe_q <= (bit_q < 4'd8) ? ~tx_q[7] : 1'b0;
                  end
                  2'd1: scl_q <= 1'b1;
                  2'd2: if (bit_q == 4'd8) smp_q <= sda;
                  2'd3: begin
                    scl_q <= 1'b0;
                    if (bit_q < 4'd8) begin
                      tx_q <= {tx_q[6:0], 1'b0};
                    end else begin
                      {bit_q, qtr_q} <= '0;
                      if (smp_q) begin
                        ack_q   <= 1'b1;
                        state_q <= STOP;
                      end else begin
                        tx_q    <= nxt_byte;
                        state_q <= nxt_state;
                      end
                    end
                  end
                endcase
              end

              // Repeated start: release SDA with SCL low, raise SCL, then
              // pull SDA low while SCL is high.
              RESTART: begin
                case (step)
                  6'd0: begin scl_q <= 1'b0; sda_oe_q <= 1'b0; end
                  6'd1: scl_q    <= 1'b1;
                  6'd2: sda_oe_q <= 1'b1;
                  6'd3: begin
                    scl_q          <= 1'b0;
                    tx_q           <= {SLAVE_ADDR, 1'b1};
                    {bit_q, qtr_q} <= '0;
                    state_q        <= DEV_R;
                  end
                  default: ;
                endcase
              end

              RD_DATA: begin
                case (qtr_q)
                  2'd0: begin scl_q <= 1'b0; sda_oe_q <= 1'b0; end
                  2'd1: scl_q <= 1'b1;
                  2'd2: rx_q  <= {rx_q[6:0], sda};
                  2'd3: begin
                    scl_q <= 1'b0;
                    if (bit_q == 4'd7) begin
                      {bit_q, qtr_q} <= '0;
                      state_q        <= MNACK;
                    end
                  end
                endcase
              end

              MNACK: begin
                case (qtr_q)
                  2'd0: begin scl_q <= 1'b0; sda_oe_q <= 1'b0; end
                  2'd1: scl_q <= 1'b1;
                  2'd2: ;
                  2'd3: begin
                    scl_q          <= 1'b0;
                    {bit_q, qtr_q} <= '0;
                    state_q        <= STOP;
                  end
                endcase
              end

              // SDA released at tick 3 with SCL high; ticks 4..7 are bus-free.
              STOP: begin
                case (step)
                  6'd0: begin scl_q <= 1'b0; sda_oe_q <= 1'b1; end
                  6'd1: scl_q    <= 1'b1;
                  6'd3: sda_oe_q <= 1'b0;
                  6'd7: begin
                    {bit_q, qtr_q} <= '0;
                    if (rw_q && !ack_q) data_r_q <= rx_q;
                    state_q <= DONE;
                  end
                  default: ;
                endcase
              end

              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign scl        = scl_q;
  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign i2c_done   = done_q;
  assign i2c_ack    = ack_q;
  assign i2c_data_r = data_r_q;

endmodule

// File: tb/tb_i2c_master_16b.sv
// tb_i2c_master_16b
//   Drives i2c_master_16b with directed and random transactions. A bus
//   monitor decodes START / repeated START / STOP / bytes from scl and sda,
//   and acts as the slave (ACK/NACK, read data). Expected bus events, frame
//   length, i2c_ack and i2c_data_r come from a transaction-level model.
module tb_i2c_master_16b;

  localparam logic [6:0]  SLV      = 7'h59;
  localparam int unsigned CLK_FREQ = 4_000_000;
  localparam int unsigned I2C_FREQ = 250_000;
  localparam int unsigned QDIV     = CLK_FREQ / (4 * I2C_FREQ);

  localparam int unsigned EV_ST = 32'h1_0000;
  localparam int unsigned EV_RS = 32'h2_0000;
  localparam int unsigned EV_SP = 32'h3_0000;
  localparam int unsigned EV_BY = 32'h4_0000;

  logic        clk;
  logic        rst_n;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [23:0] i2c_data;
  logic [7:0]  i2c_data_r;
  logic        i2c_done;
  logic        i2c_ack;
  logic        scl;
  wire         sda_bus;

  logic        slv_low;
  assign sda_bus = slv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_master_16b #(
    .SLAVE_ADDR (SLV),
    .CLK_FREQ   (CLK_FREQ),
    .I2C_FREQ   (I2C_FREQ)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i2c_exec   (i2c_exec),
    .i2c_rh_wl  (i2c_rh_wl),
    .i2c_data   (i2c_data),
    .i2c_data_r (i2c_data_r),
    .i2c_done   (i2c_done),
    .i2c_ack    (i2c_ack),
    .scl        (scl),
    .sda        (sda_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave configuration (written by the stimulus, read by the monitor)
  int          slv_nack = -1;
  logic [7:0]  slv_rd   = '0;
  int          clr_req  = 0;

  // Monitor state (written only by the monitor process)
  int unsigned ev_q[$];
  int unsigned cyc = 0, stop_cyc = 0, done_cyc = 0, last_gap = 0, done_cnt = 0;
  int          clr_seen = 0;
  int          bitcnt = 0, slot = 0;
  bit          in_frame = 0, reading = 0, first = 0;
  logic [8:0]  sh = '0;
  logic        p_scl = 1'b1, p_sda = 1'b1, s, d;

  initial begin
    slv_low = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        ev_q.delete();
        bitcnt = 0; slot = 0; in_frame = 0; reading = 0; first = 0;
        slv_low = 1'b0;
      end
      s = scl;
      d = sda_bus;
      if (i2c_done) begin done_cnt++; done_cyc = cyc; end
      if (p_scl && s) begin
        if (p_sda && !d) begin
          ev_q.push_back(in_frame ? EV_RS : EV_ST);
          if (!in_frame) slot = 0;
          in_frame = 1; bitcnt = 0; first = 1;
          last_gap = cyc - stop_cyc;
        end else if (!p_sda && d) begin
          ev_q.push_back(EV_SP);
          in_frame = 0; reading = 0; stop_cyc = cyc;
        end
      end else if (!p_scl && s && in_frame) begin
        sh = {sh[7:0], d};
        bitcnt++;
        if (bitcnt == 9) begin
          ev_q.push_back(EV_BY | 32'(sh));
          bitcnt = 0;
          if (reading) reading = 0;
          else if (first && sh[1] && !sh[0]) reading = 1;
          first = 0;
          slot++;
        end
      end else if (p_scl && !s && in_frame) begin
        if (reading && bitcnt < 8)       slv_low = ~slv_rd[3'(7 - bitcnt)];
        else if (!reading && bitcnt == 8) slv_low = (slot != slv_nack);
        else                              slv_low = 1'b0;
      end
      p_scl = s;
      p_sda = d;
    end
  end

  logic [7:0] m_dr = '0;

  task automatic run_txn(input logic rw, input logic [23:0] dat, input int nack,
                         input logic [7:0] rd, input bit busy, input bit b2b);
    int unsigned exp_q[$];
    int unsigned ticks, lat, d0;
    logic [7:0]  b, prev_dr;
    bit          nk, seen;
    // transaction-level expectation
    nk = 0;
    exp_q.push_back(EV_ST);
    ticks = 9;
    for (int i = 0; i < 4 && !nk; i++) begin
      if (rw && i == 3) begin
        exp_q.push_back(EV_RS);
        ticks += 4;
        b = {SLV, 1'b1};
      end else if (i == 0) b = {SLV, 1'b0};
      else if (i == 1)     b = dat[23:16];
      else if (i == 2)     b = dat[15:8];
      else                 b = dat[7:0];
      nk = (nack == i);
      exp_q.push_back(EV_BY | 32'({b, nk}));
      ticks += 36;
    end
    if (rw && !nk) begin
      exp_q.push_back(EV_BY | 32'({rd, 1'b1}));
      ticks += 36;
      m_dr = rd;
    end
    exp_q.push_back(EV_SP);
    ticks += 8;

    slv_nack = nack;
    slv_rd   = rd;
    clr_req++;
    d0 = done_cnt;
    i2c_exec = 1'b1; i2c_rh_wl = rw; i2c_data = dat;
    @(negedge clk); #1;
    i2c_exec = 1'b0;
    lat = 0; seen = 0; prev_dr = i2c_data_r;
    while (!seen && lat < 4000) begin
      if (i2c_done) seen = 1;
      else begin
        prev_dr = i2c_data_r;
        if (busy && lat == 200) begin i2c_exec = 1'b1; i2c_data = ~dat; i2c_rh_wl = ~rw; end
        if (busy && lat == 201) begin i2c_exec = 1'b0; i2c_data = dat;  i2c_rh_wl = rw;  end
        @(negedge clk); #1;
        lat++;
      end
    end
    check_eq("done_seen", 32'(seen), 1);
    check_eq("latency", lat, QDIV * ticks + 1);
    check_eq("ack", 32'(i2c_ack), 32'(nk));
    check_eq("data_r", 32'(i2c_data_r), 32'(m_dr));
    if (rw && !nk) check_eq("data_r_early", 32'(prev_dr), 32'(rd));
    @(negedge clk); #1;
    check_eq("done_width", 32'(i2c_done), 0);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("ev_count", ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check_eq($sformatf("ev%0d", i), ev_q[i], exp_q[i]);
    check_eq("stop_to_done", 32'(done_cyc - stop_cyc >= 4 * QDIV), 1);
    if (b2b) check_eq("bus_free", 32'(last_gap >= 4 * QDIV), 1);
  endtask

  initial begin
    int unsigned d0;
    rst_n = 1'b0; i2c_exec = 1'b0; i2c_rh_wl = 1'b0; i2c_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_scl", 32'(scl), 1);
    check_eq("rst_sda", 32'(sda_bus), 1);
    check_eq("rst_done", 32'(i2c_done), 0);
    check_eq("rst_ack", 32'(i2c_ack), 0);
    check_eq("rst_data_r", 32'(i2c_data_r), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;

    run_txn(1'b0, 24'h00035A, -1, 8'h00, 1'b0, 1'b0);   // write
    run_txn(1'b1, 24'h128100, -1, 8'h04, 1'b0, 1'b1);   // read
    run_txn(1'b0, 24'h7E11C4,  0, 8'h00, 1'b0, 1'b1);   // NACK on device address
    run_txn(1'b0, 24'h3C5AA5, -1, 8'h00, 1'b1, 1'b1);   // exec while busy
    run_txn(1'b1, 24'h0A0B0C,  3, 8'hEE, 1'b0, 1'b1);   // NACK on read address

    for (int k = 0; k < 10; k++) begin
      logic        rw;
      logic [23:0] dat;
      logic [7:0]  rd;
      int          nack;
      rw   = 1'($urandom_range(0, 1));
      dat  = 24'($urandom);
      rd   = 8'($urandom);
      nack = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(rw, dat, nack, rd, 1'b0, 1'b1);
    end

    // Reset in ADDR_L (bit 3, SCL low, master driving SDA low)
    clr_req++;
    slv_nack = -1;
    d0 = done_cnt;
    i2c_exec = 1'b1; i2c_rh_wl = 1'b0; i2c_data = 24'hA5C31E;
    @(negedge clk); #1;
    i2c_exec = 1'b0;
    repeat (391) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_scl", 32'(scl), 1);
    check_eq("mid_rst_sda", 32'(sda_bus), 1);
    check_eq("mid_rst_data_r", 32'(i2c_data_r), 0);
    m_dr = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    check_eq("mid_rst_no_done", done_cnt - d0, 0);
    run_txn(1'b0, 24'h00035A, -1, 8'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
